// File: rtl/byte_fifo.sv
// byte_fifo: single-clock first-word-fall-through FIFO with valid/ready
// handshakes on both sides. It buffers bursty producer traffic and presents
// the oldest stored word combinationally on rd_data.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high; clears pointers, count, overflow
//   wr_valid    producer offers wr_data this cycle
//   wr_data     write word (WIDTH bits)
//   wr_ready    FIFO can accept a word (not full)
//   rd_valid    rd_data holds the oldest stored word (not empty)
//   rd_data     oldest word, combinational read of mem[rd_ptr]
//   rd_ready    consumer takes rd_data this cycle
//   count       occupancy 0..DEPTH (AW+1 bits)
//   almost_full count >= AF_LEVEL
//   overflow    sticky: a write was attempted while full
module byte_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int AF_LEVEL = 28
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_ready,
  output logic [AW:0]      count,
  output logic             almost_full,
  output logic             overflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;

  // Full/empty come only from count, so each side's handshake flag is
  // independent of the other side's inputs and pointer equality is never
  // ambiguous.
  assign full        = (count == FULL_CNT);
  assign empty       = (count == '0);
  assign wr_ready    = ~full;
  assign rd_valid    = ~empty;
  assign push        = wr_valid & wr_ready;
  assign pop         = rd_valid & rd_ready;
  assign rd_data     = mem[rd_ptr];
  assign almost_full = (count >= AF_CNT);

  // Storage is deliberately left out of the reset branch: stored words are
  // discarded by clearing count/pointers, contents are don't-care.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (wr_valid && full) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_byte_fifo.sv
module tb_byte_fifo;

  logic       clk;
  logic       reset;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_ready;
  logic [5:0] count;
  logic       almost_full;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  byte_fifo #(.WIDTH(8), .DEPTH(32), .AW(5), .AF_LEVEL(28)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_ready(rd_ready), .count(count), .almost_full(almost_full),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = 8'h00;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic push_n(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1; wr_data = base + 8'(i);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = 8'h00;
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full: got %b expected 0", almost_full); end
  endtask

  task automatic test_basic();
    logic [7:0] exp [3];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_data = exp[i];
      tick();
    end
    wr_valid = 1'b0;
    checks++; if (count !== 6'd3) begin errors++; $display("FAIL basic_count: got %0d expected 3", count); end
    checks++; if (rd_data !== 8'h11) begin errors++; $display("FAIL basic_head: got %h expected 11", rd_data); end
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (rd_valid !== 1'b1 || rd_data !== exp[i]) begin errors++; $display("FAIL basic_read%0d: got v=%b %h expected v=1 %h", i, rd_valid, rd_data, exp[i]); end
      tick();
    end
    rd_ready = 1'b0;
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL basic_drain_count: got %0d expected 0", count); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_drain_valid: got %b expected 0", rd_valid); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 32; i++) begin
      checks++; if (almost_full !== (i >= 28)) begin errors++; $display("FAIL full_af_at%0d: got %b expected %b", i, almost_full, (i >= 28)); end
      wr_valid = 1'b1; wr_data = 8'(i);
      tick();
    end
    wr_valid = 1'b0;
    checks++; if (count !== 6'd32) begin errors++; $display("FAIL full_count: got %0d expected 32", count); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready: got %b expected 0", wr_ready); end
    checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL full_af: got %b expected 1", almost_full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_ovf_pre: got %b expected 0", overflow); end
    wr_valid = 1'b1; wr_data = 8'hEE;
    tick();
    wr_valid = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_ovf: got %b expected 1", overflow); end
    checks++; if (count !== 6'd32) begin errors++; $display("FAIL full_count_ovf: got %0d expected 32", count); end
    rd_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      checks++; if (rd_data !== 8'(i)) begin errors++; $display("FAIL full_drain%0d: got %h expected %h", i, rd_data, 8'(i)); end
      tick();
    end
    rd_ready = 1'b0;
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL full_drain_count: got %0d expected 0", count); end
  endtask

  task automatic test_wrap();
    apply_reset();
    push_n(20, 8'h00);
    rd_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    rd_ready = 1'b0;
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL wrap_mid_count: got %0d expected 0", count); end
    for (int i = 0; i < 20; i++) begin
      wr_valid = 1'b1; wr_data = 8'hA0 + 8'(i);
      tick();
      checks++; if (count !== 6'(i + 1)) begin errors++; $display("FAIL wrap_count%0d: got %0d expected %0d", i, count, i + 1); end
    end
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      checks++; if (rd_data !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL wrap_read%0d: got %h expected %h", i, rd_data, 8'hA0 + 8'(i)); end
      tick();
    end
    rd_ready = 1'b0;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL wrap_empty: got %b expected 0", rd_valid); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    push_n(5, 8'h40);
    wr_valid = 1'b1; rd_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wr_data = 8'h45 + 8'(k);
      checks++; if (rd_data !== 8'h40 + 8'(k)) begin errors++; $display("FAIL simul_read%0d: got %h expected %h", k, rd_data, 8'h40 + 8'(k)); end
      tick();
      checks++; if (count !== 6'd5) begin errors++; $display("FAIL simul_count%0d: got %0d expected 5", k, count); end
    end
    wr_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++; if (rd_data !== 8'h4A + 8'(k)) begin errors++; $display("FAIL simul_tail%0d: got %h expected %h", k, rd_data, 8'h4A + 8'(k)); end
      tick();
    end
    rd_ready = 1'b0;
    // Empty with both sides active: only the push happens.
    wr_valid = 1'b1; rd_ready = 1'b1; wr_data = 8'h77;
    tick();
    wr_valid = 1'b0; rd_ready = 1'b0;
    checks++; if (count !== 6'd1 || rd_data !== 8'h77) begin errors++; $display("FAIL simul_empty: got count=%0d data=%h expected count=1 data=77", count, rd_data); end
    // Full with both sides active: only the pop happens, overflow sets.
    apply_reset();
    push_n(32, 8'h80);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL simul_full_ovf_pre: got %b expected 0", overflow); end
    wr_valid = 1'b1; rd_ready = 1'b1; wr_data = 8'hFF;
    tick();
    wr_valid = 1'b0; rd_ready = 1'b0;
    checks++; if (count !== 6'd31) begin errors++; $display("FAIL simul_full_count: got %0d expected 31", count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL simul_full_ovf: got %b expected 1", overflow); end
    checks++; if (rd_data !== 8'h81) begin errors++; $display("FAIL simul_full_head: got %h expected 81", rd_data); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    push_n(32, 8'h10);
    wr_valid = 1'b1; wr_data = 8'hEE;
    tick();
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    rd_ready = 1'b0;
    checks++; if (count !== 6'd12 || overflow !== 1'b1) begin errors++; $display("FAIL rmid_pre: got count=%0d ovf=%b expected count=12 ovf=1", count, overflow); end
    #2 reset = 1'b1;
    #1;
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL rmid_count: got %0d expected 0", count); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rmid_rd_valid: got %b expected 0", rd_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rmid_overflow: got %b expected 0", overflow); end
    #1 reset = 1'b0;
    wr_valid = 1'b1; wr_data = 8'h5A;
    tick();
    wr_valid = 1'b0;
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h5A) begin errors++; $display("FAIL rmid_push: got v=%b %h expected v=1 5a", rd_valid, rd_data); end
    checks++; if (count !== 6'd1) begin errors++; $display("FAIL rmid_push_count: got %0d expected 1", count); end
  endtask

  initial begin
    reset = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = 8'h00;
    test_reset();
    test_basic();
    test_full();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
